writeback_arbiter: RTL

Single-write-port arbiter feeding the register file's write port (`write_reg`, `write_en`, `write_data`). It merges two result sources: ALU results and memory load results. ALU results take priority. Load results are buffered in a small FIFO and drained whenever the port is free. A starvation counter guarantees forward progress for loads. The block also exports a pending-write mask of queued destinations for hazard detection in decode.

---
 rtl/wb_pkg.sv | 20 ++
 rtl/wb_fifo.sv | 72 +++++++
 rtl/writeback_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package wb_pkg;

    localparam int WB_DATA_W = 64;
    localparam int NUM_REGS = 32;
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [4:0]           rd;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

    // Which source owns the write port this cycle.
    typedef enum logic [1:0] {
        WIN_NONE,
        WIN_ALU,
        WIN_FIFO
    } wb_win_t;

endpackage

// File: rtl/wb_fifo.sv
// Load-result FIFO. Also exposes per-slot valid flags and destination registers
// so the parent can build a pending-write mask without walking pointers.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = wb_entry_t
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  entry_t                push_entry,
    input  logic                  pop,
    output entry_t                head,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH-1:0]      entry_valid,
    output logic [DEPTH-1:0][4:0] entry_rd
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    // A full FIFO refuses pushes even when a pop frees a slot in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Entry storage; contents are qualified by entry_valid so no reset needed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // Pointers, occupancy count and per-slot valid flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            entry_valid <= '0;
        end else begin
            if (do_push) begin
                wr_ptr              <= wr_ptr + PW'(1);
                entry_valid[wr_ptr] <= 1'b1;
            end
            if (do_pop) begin
                rd_ptr              <= rd_ptr + PW'(1);
                entry_valid[rd_ptr] <= 1'b0;
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Flat view of each slot's destination register.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            entry_rd[i] = mem[i].rd;
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Single write-port arbiter: ALU results have priority, loads are queued and
// drained when the port is free, with a starvation limit guaranteeing loads
// eventually win. Exports a mask of destinations still waiting in the queue.
module writeback_arbiter
    import wb_pkg::*;
#(
    parameter int DATA_W     = 64,
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                alu_valid,
    output logic                alu_ready,
    input  logic [4:0]          alu_rd,
    input  logic [DATA_W-1:0]   alu_data,
    input  logic                mem_valid,
    output logic                mem_ready,
    input  logic [4:0]          mem_rd,
    input  logic [DATA_W-1:0]   mem_data,
    output logic [4:0]          write_reg,
    output logic                write_en,
    output logic [DATA_W-1:0]   write_data,
    output logic [NUM_REGS-1:0] pending_mask
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    wb_entry_t            push_entry;
    wb_entry_t            head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 push;
    logic                 pop;
    logic [DEPTH-1:0]     entry_valid;
    logic [DEPTH-1:0][4:0] entry_rd;
    logic [SW-1:0]        starve_cnt;
    logic                 forced;
    wb_win_t              win;

    wb_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (wb_entry_t)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push        (push),
        .push_entry  (push_entry),
        .pop         (pop),
        .head        (head),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .entry_valid (entry_valid),
        .entry_rd    (entry_rd)
    );

    assign mem_ready = !fifo_full;
    assign forced    = (starve_cnt == STARVE_LIM) && !fifo_empty;
    assign alu_ready = !forced;
    // Loads to r0 are accepted but dropped; loads never bypass the queue.
    assign push      = mem_valid && !fifo_full && (mem_rd != REG_ZERO);
    assign pop       = (win == WIN_FIFO);

    // Pack the incoming load into a queue entry.
    always_comb begin
        push_entry      = '0;
        push_entry.rd   = mem_rd;
        push_entry.data = mem_data;
    end

    // Port arbitration: forced drain, then ALU, then normal drain, else idle.
    always_comb begin
        win = WIN_NONE;
        if (forced) begin
            win = WIN_FIFO;
        end else if (alu_valid && (alu_rd != REG_ZERO)) begin
            win = WIN_ALU;
        end else if (!fifo_empty) begin
            win = WIN_FIFO;
        end
    end

    // Count consecutive ALU wins while loads wait; any drain or empty queue resets it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (fifo_empty || pop) begin
            starve_cnt <= '0;
        end else if ((win == WIN_ALU) && (starve_cnt != STARVE_LIM)) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

    // Registered write port towards the register file.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            write_en   <= 1'b0;
            write_reg  <= '0;
            write_data <= '0;
        end else begin
            write_en <= (win != WIN_NONE);
            case (win)
                WIN_ALU: begin
                    write_reg  <= alu_rd;
                    write_data <= alu_data;
                end
                WIN_FIFO: begin
                    write_reg  <= head.rd;
                    write_data <= head.data;
                end
                default: ;
            endcase
        end
    end

    // OR of all queued destinations; r0 never appears.
    always_comb begin
        pending_mask = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (entry_valid[i]) begin
                pending_mask[entry_rd[i]] = 1'b1;
            end
        end
        pending_mask[REG_ZERO] = 1'b0;
    end

endmodule
